bp_btb_ras: RTL and testbench

//  Stage-1 next-PC predictor: direct-mapped tagged BTB with 2-bit saturating counters, JAL target decode, circular RAS.

---
 rtl/bp_btb_ras.sv | 190 +++++++++++++++++++
 tb/tb_bp_btb_ras.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_btb_ras.sv
// bp_btb_ras: stage-1 next-PC predictor.
//   - Direct-mapped, tagged BTB with 2-bit saturating direction counters.
//   - JAL target decoded directly from the instruction word.
//   - Circular return-address stack (RAS) with a checkpoint that travels down
//     the pipeline, so EX can restore it after a mispredict.
//
// Ports:
//   clk, n_reset              clock; synchronous active-low reset
//   fetch_valid, pc, instr    current fetch slot; predicted combinationally
//   pred_pc, pred_taken       predicted next PC; 1 = not a sequential pc+4
//   ras_ckpt, ras_ptr         RAS count and top pointer before this fetch's update
//   upd_valid, upd_pc,
//   upd_taken, upd_target     EX-stage resolution used to train the BTB
//   flush, rst_ptr, rst_cnt   EX mispredict; restores the RAS pointer and count
//   perf_mispred              saturating count of cycles with flush high
module bp_btb_ras #(
    parameter int         PC_W        = 48,
    parameter int         BTB_ENTRIES = 256,
    parameter int         TAG_W       = 16,
    parameter int         RAS_DEPTH   = 8,
    parameter logic [1:0] CTR_INIT    = 2'b10,
    localparam int        IDX_W       = $clog2(BTB_ENTRIES),
    localparam int        P_W         = $clog2(RAS_DEPTH)
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            fetch_valid,
    input  logic [PC_W-1:0] pc,
    input  logic [31:0]     instr,
    output logic [PC_W-1:0] pred_pc,
    output logic            pred_taken,
    output logic [P_W:0]    ras_ckpt,
    output logic [P_W-1:0]  ras_ptr,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            flush,
    input  logic [P_W-1:0]  rst_ptr,
    input  logic [P_W:0]    rst_cnt,
    output logic [31:0]     perf_mispred
);

    localparam logic [P_W:0] RAS_FULL = (P_W+1)'(RAS_DEPTH);

    // ---------------- storage ----------------
    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
    logic [PC_W-1:0]        btb_tgt [BTB_ENTRIES];
    logic [1:0]             btb_ctr [BTB_ENTRIES];

    logic [PC_W-1:0]        ras_mem [RAS_DEPTH];
    logic [P_W-1:0]         ptr_q;
    logic [P_W:0]           cnt_q;

    // ---------------- decode ----------------
    logic [6:0]      opcode;
    logic [4:0]      rd, rs1;
    logic            is_jal, is_jalr;
    logic            link_rd, link_rs1;
    logic            want_push, want_pop, want_repl;
    logic            ras_empty, ras_full;
    logic            op_push, op_pop, op_repl;
    logic [P_W-1:0]  ptr_m1;
    logic [PC_W-1:0] pc_plus4, jal_imm;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign rs1      = instr[19:15];
    assign is_jal   = (opcode == 7'h6f);
    assign is_jalr  = (opcode == 7'h67) && (instr[14:12] == 3'b000);
    assign link_rd  = (rd  == 5'd1) || (rd  == 5'd5);
    assign link_rs1 = (rs1 == 5'd1) || (rs1 == 5'd5);

    // Return-address hint table: JAL to a link register is a call; for JALR the
    // (rd, rs1) link pattern selects call, return, or coroutine swap (replace).
    assign want_push = (is_jal && link_rd) ||
                       (is_jalr && link_rd && (!link_rs1 || (rd == rs1)));
    assign want_pop  = is_jalr && !link_rd && link_rs1;
    assign want_repl = is_jalr && link_rd && link_rs1 && (rd != rs1);

    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == RAS_FULL);
    assign ptr_m1    = ptr_q - 1'b1;

    // Popping an empty stack is a no-op; a replace on an empty stack therefore
    // degenerates to a plain push of the new link address.
    assign op_pop  = want_pop && !ras_empty;
    assign op_repl = want_repl && !ras_empty;
    assign op_push = want_push || (want_repl && ras_empty);

    assign pc_plus4 = pc + PC_W'(4);
    assign jal_imm  = {{(PC_W-21){instr[31]}}, instr[31], instr[19:12],
                       instr[20], instr[30:21], 1'b0};

    // ---------------- BTB lookup ----------------
    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_hit, u_hit;

    assign l_idx = pc[IDX_W+1:2];
    assign l_tag = pc[IDX_W+2+TAG_W-1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[IDX_W+2+TAG_W-1:IDX_W+2];
    assign l_hit = btb_valid[l_idx] && (btb_tag[l_idx] == l_tag);
    assign u_hit = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);

    // ---------------- prediction ----------------
    always_comb begin
        pred_pc    = pc_plus4;
        pred_taken = 1'b0;
        if (n_reset) begin
            if (op_pop || op_repl) begin
                pred_pc    = ras_mem[ptr_m1];
                pred_taken = 1'b1;
            end else if (is_jal) begin
                pred_pc    = pc + jal_imm;
                pred_taken = 1'b1;
            end else if (l_hit && btb_ctr[l_idx][1]) begin
                pred_pc    = btb_tgt[l_idx];
                pred_taken = 1'b1;
            end
        end
    end

    assign ras_ckpt = cnt_q;
    assign ras_ptr  = ptr_q;

    // ---------------- RAS state ----------------
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            ptr_q <= rst_ptr;
            cnt_q <= rst_cnt;
        end else if (fetch_valid) begin
            if (op_push) begin
                ptr_q <= ptr_q + 1'b1;
                // A full stack keeps its count; the oldest entry is overwritten.
                if (!ras_full) cnt_q <= cnt_q + 1'b1;
            end else if (op_pop) begin
                ptr_q <= ptr_m1;
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Entry data is not reset and is left alone by a flush.
    always_ff @(posedge clk) begin
        if (n_reset && fetch_valid && !flush) begin
            if (op_push)      ras_mem[ptr_q]  <= pc_plus4;
            else if (op_repl) ras_mem[ptr_m1] <= pc_plus4;
        end
    end

    // ---------------- BTB training ----------------
    always_ff @(posedge clk) begin
        if (!n_reset)
            btb_valid <= '0;
        else if (upd_valid && !u_hit && upd_taken)
            btb_valid[u_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (n_reset && upd_valid) begin
            if (u_hit) begin
                if (upd_taken) begin
                    if (btb_ctr[u_idx] != 2'b11) btb_ctr[u_idx] <= btb_ctr[u_idx] + 2'b01;
                    btb_tgt[u_idx] <= upd_target;
                end else if (btb_ctr[u_idx] != 2'b00) begin
                    btb_ctr[u_idx] <= btb_ctr[u_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                btb_tag[u_idx] <= u_tag;
                btb_tgt[u_idx] <= upd_target;
                btb_ctr[u_idx] <= CTR_INIT;
            end
        end
    end

    // ---------------- performance counter ----------------
    always_ff @(posedge clk) begin
        if (!n_reset)
            perf_mispred <= '0;
        else if (flush && (perf_mispred != 32'hFFFF_FFFF))
            perf_mispred <= perf_mispred + 32'd1;
    end

endmodule

// File: tb/tb_bp_btb_ras.sv
// Bench for bp_btb_ras. Inputs change 1 time unit after the rising edge;
// predictions are sampled on the falling edge.
module tb_bp_btb_ras;

  localparam int PC_W = 48;
  localparam int P_W  = 3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            n_reset = 1'b0;
  logic            fetch_valid = 1'b0;
  logic [PC_W-1:0] pc = '0;
  logic [31:0]     instr = NOP;
  logic [PC_W-1:0] pred_pc;
  logic            pred_taken;
  logic [P_W:0]    ras_ckpt;
  logic [P_W-1:0]  ras_ptr;
  logic            upd_valid = 1'b0;
  logic [PC_W-1:0] upd_pc = '0;
  logic            upd_taken = 1'b0;
  logic [PC_W-1:0] upd_target = '0;
  logic            flush = 1'b0;
  logic [P_W-1:0]  rst_ptr = '0;
  logic [P_W:0]    rst_cnt = '0;
  logic [31:0]     perf_mispred;

  always #5 clk = ~clk;

  bp_btb_ras dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .fetch_valid  (fetch_valid),
    .pc           (pc),
    .instr        (instr),
    .pred_pc      (pred_pc),
    .pred_taken   (pred_taken),
    .ras_ckpt     (ras_ckpt),
    .ras_ptr      (ras_ptr),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .flush        (flush),
    .rst_ptr      (rst_ptr),
    .rst_cnt      (rst_cnt),
    .perf_mispred (perf_mispred)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [PC_W:0] exp_q[$];   // {taken, pc}

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h000, rs1, 3'b000, rd, 7'h67};
  endfunction

  // ---------------- driver tasks ----------------
  // Called 1 unit after a rising edge; occupies exactly one cycle.
  task automatic fetch(input string tag, input logic [PC_W-1:0] p, input logic [31:0] ins,
                       input logic [PC_W-1:0] e_pc, input logic e_tk);
    logic [PC_W:0] e;
    pc = p;
    instr = ins;
    fetch_valid = 1'b1;
    exp_q.push_back({e_tk, e_pc});
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, {15'b0, pred_taken, pred_pc}, {15'b0, e});
    @(posedge clk);
    #1;
    fetch_valid = 1'b0;
    upd_valid = 1'b0;
    flush = 1'b0;
    pc = '0;
    instr = NOP;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic update(input logic [PC_W-1:0] p, input logic tk, input logic [PC_W-1:0] tgt);
    upd_valid = 1'b1;
    upd_pc = p;
    upd_taken = tk;
    upd_target = tgt;
    idle();
  endtask

  task automatic do_reset();
    logic [PC_W-1:0] rp;
    n_reset = 1'b0;
    rp = 48'h0000_0000_1000;
    pc = rp;
    instr = enc_jal(5'd1, 21'h100);
    fetch_valid = 1'b1;
    @(negedge clk);
    check("reset_pred", {15'b0, pred_taken, pred_pc}, {15'b0, 1'b0, rp + 48'd4});
    @(posedge clk);
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    fetch_valid = 1'b0;
    pc = '0;
    instr = NOP;
    check("reset_cnt", 64'(ras_ckpt), 64'd0);
    check("reset_ptr", 64'(ras_ptr), 64'd0);
    check("reset_perf", 64'(perf_mispred), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [PC_W-1:0] p, a[10];
  logic [P_W-1:0]  ck_p;
  logic [P_W:0]    ck_c;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 1: random pcs with non-branch instructions never predict taken
    for (int i = 0; i < 20; i++) begin
      p = {16'($urandom_range(0, 16'hFFFF)), 32'($urandom)} & ~48'h3;
      fetch("seq", p, NOP, p + 48'd4, 1'b0);
    end

    // 2: call then return
    fetch("jal", 48'h1000, enc_jal(5'd1, 21'h100), 48'h1100, 1'b1);
    check("jal_cnt", 64'(ras_ckpt), 64'd1);
    fetch("ret", 48'h1100, enc_jalr(5'd0, 5'd1), 48'h1004, 1'b1);
    check("ret_cnt", 64'(ras_ckpt), 64'd0);

    // 3: BTB allocate, train down, train up
    update(48'h2000, 1'b1, 48'h3000);
    fetch("btb_alloc", 48'h2000, NOP, 48'h3000, 1'b1);
    update(48'h2000, 1'b0, 48'h0);
    update(48'h2000, 1'b0, 48'h0);
    fetch("btb_nt", 48'h2000, NOP, 48'h2004, 1'b0);
    update(48'h2000, 1'b1, 48'h3000);
    fetch("btb_weak_nt", 48'h2000, NOP, 48'h2004, 1'b0);
    update(48'h2000, 1'b1, 48'h3000);
    fetch("btb_tk", 48'h2000, NOP, 48'h3000, 1'b1);

    // 4: overflow the RAS, then drain it
    do_reset();
    for (int i = 0; i < 10; i++) begin
      p = 48'h4000 + 48'(i * 16);
      a[i] = p + 48'd4;
      fetch("push", p, enc_jal((i % 2) ? 5'd5 : 5'd1, 21'h8), p + 48'd8, 1'b1);
    end
    check("full_cnt", 64'(ras_ckpt), 64'd8);
    check("full_ptr", 64'(ras_ptr), 64'd2);
    for (int i = 9; i >= 2; i--)
      fetch("pop", 48'h5004, enc_jalr(5'd0, (i % 2) ? 5'd1 : 5'd5), a[i], 1'b1);
    fetch("pop_empty", 48'h5004, enc_jalr(5'd0, 5'd1), 48'h5008, 1'b0);
    check("empty_cnt", 64'(ras_ckpt), 64'd0);

    // 5: checkpoint restore discards the same-cycle push
    do_reset();
    fetch("push_a", 48'h6000, enc_jal(5'd1, 21'h40), 48'h6040, 1'b1);
    ck_p = ras_ptr;
    ck_c = ras_ckpt;
    check("ckpt_cnt", 64'(ck_c), 64'd1);
    check("ckpt_ptr", 64'(ck_p), 64'd1);
    fetch("push_b", 48'h7000, enc_jal(5'd1, 21'h40), 48'h7040, 1'b1);
    flush = 1'b1;
    rst_ptr = ck_p;
    rst_cnt = ck_c;
    fetch("push_c_flush", 48'h8000, enc_jal(5'd1, 21'h40), 48'h8040, 1'b1);
    check("flush_cnt", 64'(ras_ckpt), 64'd1);
    check("perf_one", 64'(perf_mispred), 64'd1);
    fetch("pop_a", 48'h9000, enc_jalr(5'd0, 5'd1), 48'h6004, 1'b1);
    fetch("pop_none", 48'h9000, enc_jalr(5'd0, 5'd1), 48'h9004, 1'b0);
    flush = 1'b1;
    rst_ptr = '0;
    rst_cnt = '0;
    idle();
    flush = 1'b1;
    idle();
    check("perf_three", 64'(perf_mispred), 64'd3);

    // 6: same-cycle update/lookup, then aliasing index
    do_reset();
    upd_valid = 1'b1;
    upd_pc = 48'hA000;
    upd_taken = 1'b1;
    upd_target = 48'hB000;
    fetch("same_cyc_old", 48'hA000, NOP, 48'hA004, 1'b0);
    fetch("same_cyc_new", 48'hA000, NOP, 48'hB000, 1'b1);
    fetch("alias_miss", 48'hA400, NOP, 48'hA404, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
